// File: rtl/clk_div_pkg.sv
// Shared clock-divider constants and helpers.
// Used by clk_div_param and the timer/display timebases.
package clk_div_pkg;

  localparam int CLK_DIV_MIN = 2;

  // High-phase length of a divide-by-d square wave: ceil(d/2).
  function automatic logic [31:0] clk_div_half(input logic [31:0] d);
    return d - (d >> 1);
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Counter, wrap detect, tick strobe and square output.
// sq_out is built only when CLK_DIV_SQUARE_EN is defined.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] div_cur,
`ifdef CLK_DIV_SQUARE_EN
  input  logic [WIDTH-1:0] div_nxt,
`endif
  output logic             wrap,
  output logic             tick,
  output logic             sq_out
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;

  always_comb begin
    wrap    = en && !clr && (cnt == div_cur - WIDTH'(1));
    cnt_nxt = cnt;
    if (clr || wrap)
      cnt_nxt = '0;
    else if (en)
      cnt_nxt = cnt + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      tick <= wrap;
    end
  end

`ifdef CLK_DIV_SQUARE_EN
  logic [WIDTH-1:0] half;

  // Uses the divisor that will be active after this edge.
  assign half = WIDTH'(clk_div_half(32'(div_nxt)));

  always_ff @(posedge clk) begin
    if (rst)
      sq_out <= 1'b1;
    else if (clr || en)
      sq_out <= (cnt_nxt < half);
  end
`else
  assign sq_out = 1'b0;
`endif

endmodule

// File: rtl/clk_div_param.sv
// Runtime-loadable clock-enable divider with glitch-free divisor swap.
// Define CLK_DIV_SQUARE_EN to build the sq_out square output.
module clk_div_param
  import clk_div_pkg::*;
#(
  parameter int WIDTH       = 7,
  parameter int DEFAULT_DIV = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_value,
  output logic             tick,
  output logic             sq_out,
  output logic [WIDTH-1:0] div_active,
  output logic             div_pending,
  output logic             div_err
);

  logic [WIDTH-1:0] pend;
  logic [WIDTH-1:0] div_nxt;
  logic             valid;
  logic             apply;
  logic             wrap;

  assign valid = div_load && (div_value >= WIDTH'(CLK_DIV_MIN));
  assign apply = wrap || clr;

  // Divisors only change at cnt = 0, so a period is never cut short.
  always_comb begin
    div_nxt = div_active;
    if (apply) begin
      if (valid)
        div_nxt = div_value;
      else if (div_pending)
        div_nxt = pend;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend        <= '0;
      div_active  <= WIDTH'(DEFAULT_DIV);
      div_pending <= 1'b0;
      div_err     <= 1'b0;
    end else begin
      div_err    <= div_load && !valid;
      div_active <= div_nxt;
      if (apply) begin
        div_pending <= 1'b0;
      end else if (valid) begin
        pend        <= div_value;
        div_pending <= 1'b1;
      end
    end
  end

  clk_div_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .clr    (clr),
    .div_cur(div_active),
`ifdef CLK_DIV_SQUARE_EN
    .div_nxt(div_nxt),
`endif
    .wrap   (wrap),
    .tick   (tick),
    .sq_out (sq_out)
  );

endmodule

// File: tb/tb_clk_div_param.sv
// Directed bench for clk_div_param (WIDTH=7, DEFAULT_DIV=100).
// Expected sq_out is constant 0 unless CLK_DIV_SQUARE_EN is defined.
module tb_clk_div_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic       div_load = 1'b0;
  logic [6:0] div_value = '0;
  logic       tick;
  logic       sq_out;
  logic [6:0] div_active;
  logic       div_pending;
  logic       div_err;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef CLK_DIV_SQUARE_EN
  localparam bit SQ = 1'b1;
`else
  localparam bit SQ = 1'b0;
`endif

  always #5 clk = ~clk;

  clk_div_param #(
    .WIDTH      (7),
    .DEFAULT_DIV(100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clr        (clr),
    .div_load   (div_load),
    .div_value  (div_value),
    .tick       (tick),
    .sq_out     (sq_out),
    .div_active (div_active),
    .div_pending(div_pending),
    .div_err    (div_err)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sq_exp(input bit v);
    return (SQ && v) ? 1 : 0;
  endfunction

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_tick"}, int'(tick), 0);
    check({tag, "_sq"}, int'(sq_out), sq_exp(1'b1));
    check({tag, "_act"}, int'(div_active), 100);
    check({tag, "_pend"}, int'(div_pending), 0);
    check({tag, "_err"}, int'(div_err), 0);
  endtask

  initial begin
    // reset, then free run: ticks after enabled edges 100 and 200
    run(2);
    check_reset("rst0");
    rst = 1'b0;
    en  = 1'b1;
    for (int i = 1; i <= 250; i++) begin
      run(1);
      check("s1_tick", int'(tick), (i % 100 == 0) ? 1 : 0);
      check("s1_sq", int'(sq_out), sq_exp((i % 100) < 50));
    end
    check("s1_act", int'(div_active), 100);

    // pause 17 cycles at cnt=70: sq holds low, tick delayed
    run(20);
    check("s2_sq_pre", int'(sq_out), sq_exp(1'b0));
    en = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      run(1);
      check("s2_hold_tick", int'(tick), 0);
      check("s2_hold_sq", int'(sq_out), sq_exp(1'b0));
    end
    en = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      run(1);
      check("s2_tick", int'(tick), (k == 30) ? 1 : 0);
    end

    // rejected loads of 1 and 0 (cnt 0 -> 4)
    div_load  = 1'b1;
    div_value = 7'd1;
    run(1);
    check("s4_err1", int'(div_err), 1);
    check("s4_pend1", int'(div_pending), 0);
    check("s4_act1", int'(div_active), 100);
    div_load = 1'b0;
    run(1);
    check("s4_err1_off", int'(div_err), 0);
    div_load  = 1'b1;
    div_value = 7'd0;
    run(1);
    check("s4_err0", int'(div_err), 1);
    check("s4_pend0", int'(div_pending), 0);
    check("s4_act0", int'(div_active), 100);
    div_load = 1'b0;
    run(1);
    check("s4_err0_off", int'(div_err), 0);

    // clr + load 5 at cnt=60: active immediately
    run(56);
    clr       = 1'b1;
    div_load  = 1'b1;
    div_value = 7'd5;
    run(1);
    check("s5_act", int'(div_active), 5);
    check("s5_pend", int'(div_pending), 0);
    check("s5_tick", int'(tick), 0);
    check("s5_sq", int'(sq_out), sq_exp(1'b1));
    clr      = 1'b0;
    div_load = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      run(1);
      check("s5_tick_k", int'(tick), (k == 5) ? 1 : 0);
      check("s5_sq_k", int'(sq_out), sq_exp((k % 5) < 3));
    end

    // back to defaults via reset with en held high
    rst = 1'b1;
    run(1);
    check_reset("rst1");
    rst = 1'b0;

    // load 7 at cnt=40: pending until the wrap at 99
    run(40);
    div_load  = 1'b1;
    div_value = 7'd7;
    run(1);
    check("s3_pend", int'(div_pending), 1);
    check("s3_act_old", int'(div_active), 100);
    div_load = 1'b0;
    run(58);
    check("s3_pend_99", int'(div_pending), 1);
    check("s3_tick_99", int'(tick), 0);
    run(1);
    check("s3_wrap_tick", int'(tick), 1);
    check("s3_act", int'(div_active), 7);
    check("s3_pend_off", int'(div_pending), 0);
    check("s3_sq0", int'(sq_out), sq_exp(1'b1));
    for (int k = 1; k <= 7; k++) begin
      run(1);
      check("s3_tick_k", int'(tick), (k == 7) ? 1 : 0);
      check("s3_sq_k", int'(sq_out), sq_exp((k % 7) < 4));
    end

    // load 100 coincident with a wrap: applied directly
    run(6);
    div_load  = 1'b1;
    div_value = 7'd100;
    run(1);
    check("wl_tick", int'(tick), 1);
    check("wl_act", int'(div_active), 100);
    check("wl_pend", int'(div_pending), 0);
    div_load = 1'b0;

    // reset at cnt=30 with 20 pending: period restarts at 100
    run(29);
    div_load  = 1'b1;
    div_value = 7'd20;
    run(1);
    check("s6_pend", int'(div_pending), 1);
    div_load = 1'b0;
    rst      = 1'b1;
    run(1);
    check_reset("s6_rst");
    rst = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      run(1);
      check("s6_tick", int'(tick), (k == 100) ? 1 : 0);
    end
    check("s6_act", int'(div_active), 100);
    check("s6_pend_end", int'(div_pending), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clk_div_param.md
# clk_div_param

Parametrised clock-enable generator for the microwave controller. It divides `clk` by a runtime-loadable divisor and produces two outputs: a one-cycle `tick` strobe, and a near-50 % square `sq_out` for the display, buzzer and encoder timebases. It replaces fixed divide-by-100 counters with a single block that supports enable, phase clear and glitch-free divisor changes.

## Interface
Parameters:
- `WIDTH`, default 7: width of the counter and divisor.
- `DEFAULT_DIV`, default 100: active divisor after reset. Must satisfy 2 ≤ DEFAULT_DIV ≤ 2^WIDTH−1.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: count enable.
- `clr` in 1: synchronous phase clear. Forces `cnt` to 0 and applies any pending divisor.
- `div_load` in 1: request to load `div_value`.
- `div_value` in WIDTH: requested divisor D.
- `tick` out 1: one-cycle strobe, high once per D enabled cycles.
- `sq_out` out 1: square output.
- `div_active` out WIDTH: divisor currently in use.
- `div_pending` out 1: a loaded divisor is waiting to be applied.
- `div_err` out 1: one-cycle strobe when a load is rejected.

## Operation
- Internal `cnt` runs 0..D−1 on enabled edges. At cnt = D−1 it wraps to 0 and sets `tick` = 1 for one cycle. On every other edge `tick` = 0.
- `en` = 0: `cnt`, `sq_out` and `div_active` hold. `tick` = 0.
- `clr` = 1, which has priority over `en`: `cnt` ← 0, `sq_out` ← 1, `tick` ← 0, and any pending divisor is applied.
- Loading:
  - `div_load` with `div_value` < 2 is rejected. `div_err` = 1 next cycle; pending state is unchanged.
  - Otherwise the value is stored in `pend` and `div_pending` ← 1.
  - A new load while pending overwrites `pend`.
- Applying: `pend` is copied to `div_active` only at a wrap edge or a `clr` edge, and `div_pending` then falls.
  - If `div_load` coincides with a wrap or `clr`, the incoming `div_value` is applied directly at that edge. `div_pending` stays 0.
  - Changing the divisor never truncates or extends the current period.
- Square output: H = D − (D >> 1), computed with the D in effect after the edge. `sq_out` is registered as (cnt_next < H).
  - The output is high for ceil(D/2) cycles and low for floor(D/2) cycles.
  - Example: D = 3 gives 2 cycles high, 1 low.
- Arithmetic: unsigned WIDTH-bit throughout. `cnt` can never exceed D−1, because D changes only when `cnt` = 0.
- Reset values: `cnt` = 0, `tick` = 0, `sq_out` = 1, `div_active` = DEFAULT_DIV, `div_pending` = 0, `div_err` = 0, `pend` = 0.
- Reset asserted mid-period abandons the period and the pending load with no `tick`.

## Timing
- Every output is a register; there are no combinational paths from input to output.
- With `en` rising at edge 0, the first `tick` is high in the cycle following edge D. Subsequent ticks follow every D enabled cycles.
- `clr` latency is 1 cycle. After `clr` falls, with `en` held high, the next `tick` follows D edges later.
- `div_err` latency is 1 cycle. `div_pending` rises 1 cycle after the load.
- Simultaneous events:
  - `rst` beats everything.
  - `clr` beats `en`.
  - `div_load` plus wrap: the new value is active for the next period.
  - `div_load` plus `clr`: the new value is active immediately.

## Configuration
- Macro `CLK_DIV_SQUARE_EN`.
- Defined: H computation and the `sq_out` register are built as described above.
- Undefined: `sq_out` is tied to constant 0 (including during reset) and the H logic is removed. `tick`, the loading logic and `div_err` are unaffected.

## Structure
- Shared package `clk_div_pkg` holds:
  - constant `CLK_DIV_MIN` = 2;
  - function `clk_div_half(d)` returning d − (d >> 1);
  - reuse of these by the timer and display blocks.
- One sub-module, `clk_div_core`, contains `cnt`, wrap detect, `tick` and `sq_out` for a given active divisor.
- The top level holds the `pend`/`div_active` load logic, validation and `div_err`.

## Test plan
All scenarios use WIDTH=7, DEFAULT_DIV=100.
- Reset, then `en`=1 for 250 cycles: ticks at cycles 100 and 200 only. `sq_out` is high 50 and low 50 per period. `div_active`=100.
- `en` toggled low for 17 cycles mid-period: the tick is delayed by exactly 17 cycles, and `sq_out` holds its level during the pause.
- Load 7 at cnt=40: `div_pending`=1 until the wrap at 99. The next period is 7 cycles with `sq_out` 4 high / 3 low. `div_pending` then falls to 0.
- Load 1, then load 0: `div_err` pulses each time. `div_active` stays 100 and `div_pending` stays 0.
- `div_load`(5) coincident with `clr` at cnt=60: `cnt`=0 and `div_active`=5 next cycle. The first tick follows 5 cycles after `clr` deasserts.
- `rst` asserted at cnt=30 with a pending load of 20: all outputs return to their reset values, there is no tick, and the period restarts at 100.
